seg_scan_ctrl: RTL and testbench

- Parametrised, time-multiplexed seven-segment display controller; successor to the combinational hex-to-segment converter.
- Latches a hex word, per-digit decimal points and per-digit blink enables, then drives a shared segment bus and one-hot digit anodes.
- Generates its own blink phase and inter-digit ghost blanking.
- Updates the displayed value tear-free, at frame boundaries only.
- Sits between the CPU/IO bus and the board display pins.

---
 rtl/seg_pkg.sv | 20 ++
 rtl/seg_hex_decode.sv | 12 +
 rtl/seg_scan_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants, hex glyph table and width helper for the segment scanner
package seg_pkg;

    localparam logic [7:0] SEG_OFF_AH = 8'h00;

    // Active-high gfedcba glyphs for 0..F
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

    function automatic int seg_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// rtl/seg_hex_decode.sv - combinational nibble + decimal point to active-high {dp,gfedcba}
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] pattern
);

    assign pattern = {dp, seg_decode(nibble)};

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - time-multiplexed seven-segment scanner with blink and tear-free update
// Optional leading-zero suppression: SEG_LEADING_ZERO_BLANK_EN
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS       = 8,
    parameter int SCAN_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int FLASH_FRAMES = 64,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   hexs,
    input  logic [DIGITS-1:0]     points,
    input  logic [DIGITS-1:0]     les,
    input  logic                  flash_en,
    input  logic                  load,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            seg,
    output logic                  frame_done
);

    localparam int IW = seg_idx_w(DIGITS);
    localparam int CW = seg_idx_w(SCAN_CYCLES);
    localparam int FW = seg_idx_w(FLASH_FRAMES);
    localparam logic [CW-1:0]     SLOT_LAST  = CW'(SCAN_CYCLES - 1);
    localparam logic [CW-1:0]     SLOT_BLANK = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [FW-1:0]     FRAME_LAST = FW'(FLASH_FRAMES - 1);
    localparam logic [DIGITS-1:0] AN_OFF     = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [7:0]        SEG_OFF    = (ACTIVE_LOW != 0) ? ~SEG_OFF_AH : SEG_OFF_AH;

    logic [CW-1:0]       slot_q, slot_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [FW-1:0]       frame_q, frame_d;
    logic                phase_q, phase_d;
    logic                pending_q, pending_d;
    logic [4*DIGITS-1:0] sh_hex_q, sh_hex_d, act_hex_q, act_hex_d;
    logic [DIGITS-1:0]   sh_pts_q, sh_pts_d, act_pts_q, act_pts_d;
    logic [DIGITS-1:0]   sh_les_q, sh_les_d, act_les_q, act_les_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [7:0]          seg_q, seg_d;
    logic                frame_done_q, frame_done_d;

    logic                tick, boundary, update;
    logic [4*DIGITS-1:0] new_hex;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic [7:0]          dec_ah, pat_ah;

    assign tick     = (slot_q == SLOT_LAST);
    assign boundary = tick && (idx_q == IDX_LAST);
    assign update   = boundary && (pending_q || load);
    assign new_hex  = load ? hexs : sh_hex_q;
    assign cur_nib  = act_hex_q[{idx_q, 2'b00} +: 4];
    assign cur_dp   = act_pts_q[idx_q];

    seg_hex_decode u_dec (
        .nibble  (cur_nib),
        .dp      (cur_dp),
        .pattern (dec_ah)
    );

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] sup_q, sup_d;
    logic              zero_run;

    // A digit is suppressed while every nibble from it upward is zero; digit 0 always shows
    always_comb begin
        sup_d    = sup_q;
        zero_run = 1'b1;
        if (update) begin
            sup_d = '0;
            for (int i = DIGITS - 1; i > 0; i--) begin
                zero_run = zero_run && (new_hex[4*i +: 4] == 4'h0);
                sup_d[i] = zero_run;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sup_q <= ~DIGITS'(1);
        else        sup_q <= sup_d;
    end

    assign pat_ah = sup_q[idx_q] ? {cur_dp, 7'h00} : dec_ah;
`else
    assign pat_ah = dec_ah;
`endif

    always_comb begin
        slot_d    = slot_q + CW'(1);
        idx_d     = idx_q;
        frame_d   = frame_q;
        phase_d   = phase_q;
        pending_d = pending_q;
        sh_hex_d  = sh_hex_q;
        sh_pts_d  = sh_pts_q;
        sh_les_d  = sh_les_q;
        act_hex_d = act_hex_q;
        act_pts_d = act_pts_q;
        act_les_d = act_les_q;

        if (tick) begin
            slot_d = '0;
            idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
        if (load) begin
            sh_hex_d  = hexs;
            sh_pts_d  = points;
            sh_les_d  = les;
            pending_d = 1'b1;
        end
        if (boundary) begin
            pending_d = 1'b0;
            if (update) begin
                act_hex_d = new_hex;
                act_pts_d = load ? points : sh_pts_q;
                act_les_d = load ? les    : sh_les_q;
            end
            // Frame counter keeps running; the phase only advances while blinking is enabled
            if (frame_q == FRAME_LAST) begin
                frame_d = '0;
                if (flash_en) phase_d = ~phase_q;
            end else begin
                frame_d = frame_q + FW'(1);
            end
        end
    end

    logic [DIGITS-1:0] one_hot, an_ah;
    logic [7:0]        seg_ah;

    always_comb begin
        one_hot        = '0;
        one_hot[idx_q] = 1'b1;
        an_ah          = (slot_q < SLOT_BLANK) ? '0 : one_hot;
        seg_ah         = (act_les_q[idx_q] && flash_en && phase_q) ? SEG_OFF_AH : pat_ah;
        an_d           = (ACTIVE_LOW != 0) ? ~an_ah : an_ah;
        seg_d          = (ACTIVE_LOW != 0) ? ~seg_ah : seg_ah;
        frame_done_d   = boundary;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q       <= '0;
            idx_q        <= '0;
            frame_q      <= '0;
            phase_q      <= 1'b0;
            pending_q    <= 1'b0;
            sh_hex_q     <= '0;
            sh_pts_q     <= '0;
            sh_les_q     <= '0;
            act_hex_q    <= '0;
            act_pts_q    <= '0;
            act_les_q    <= '0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            frame_done_q <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            idx_q        <= idx_d;
            frame_q      <= frame_d;
            phase_q      <= phase_d;
            pending_q    <= pending_d;
            sh_hex_q     <= sh_hex_d;
            sh_pts_q     <= sh_pts_d;
            sh_les_q     <= sh_les_d;
            act_hex_q    <= act_hex_d;
            act_pts_q    <= act_pts_d;
            act_les_q    <= act_les_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed table plus randomized model comparison for seg_scan_ctrl
module tb_seg_scan_ctrl;

    localparam int D  = 8;
    localparam int S  = 4;
    localparam int B  = 1;
    localparam int FF = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] hexs = '0;
    logic [7:0]  points = '0;
    logic [7:0]  les = '0;
    logic        flash_en = 1'b0;
    logic        load = 1'b0;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic        frame_done;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .DIGITS(D), .SCAN_CYCLES(S), .BLANK_CYCLES(B), .FLASH_FRAMES(FF), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hexs(hexs), .points(points), .les(les),
        .flash_en(flash_en), .load(load), .an(an), .seg(seg), .frame_done(frame_done)
    );

    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    int vectors = 0;
    int miscompares = 0;

    // Reference state: edges since reset, latched values and blink bookkeeping
    int          m_e, cur_e, m_bcount;
    logic [31:0] m_act_hex, m_sh_hex;
    logic [7:0]  m_act_pts, m_sh_pts, m_act_les, m_sh_les;
    bit          m_pend, m_phase;
    logic [7:0]  exp_an, exp_seg;
    logic        exp_fd;

    typedef struct {
        int         edge_n;
        logic [7:0] an;
        logic [7:0] seg;
        logic       fd;
    } dir_t;
    dir_t tbl [12];

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s edge %0d: got %h want %h", name, cur_e, got, want);
        end
    endtask

    task automatic model_reset();
        m_e = 0; m_bcount = 0; m_pend = 0; m_phase = 0;
        m_act_hex = '0; m_sh_hex = '0; m_act_pts = '0; m_sh_pts = '0;
        m_act_les = '0; m_sh_les = '0;
    endtask

    task automatic step();
        int         slot, idx;
        bit         bnd;
        logic [3:0] nib;
        logic [7:0] an_ah, seg_ah;
        @(posedge clk);
        slot   = m_e % S;
        idx    = (m_e / S) % D;
        bnd    = (slot == S - 1) && (idx == D - 1);
        an_ah  = (slot < B) ? 8'h00 : 8'(1 << idx);
        nib    = 4'(m_act_hex >> (4 * idx));
        seg_ah = {m_act_pts[idx], GLYPH[nib]};
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (idx > 0 && (m_act_hex >> (4 * idx)) == 32'h0) seg_ah[6:0] = 7'h00;
`endif
        if (m_act_les[idx] && flash_en && m_phase) seg_ah = 8'h00;
        exp_an  = ~an_ah;
        exp_seg = ~seg_ah;
        exp_fd  = bnd;
        if (load) begin
            m_sh_hex = hexs; m_sh_pts = points; m_sh_les = les; m_pend = 1;
        end
        if (bnd) begin
            if (m_pend) begin
                m_act_hex = m_sh_hex; m_act_pts = m_sh_pts; m_act_les = m_sh_les;
            end
            m_pend = 0;
            m_bcount++;
            if (m_bcount % FF == 0 && flash_en) m_phase = ~m_phase;
        end
        cur_e = m_e;
        m_e++;
        @(negedge clk);
        check8("an", an, exp_an);
        check8("seg", seg, exp_seg);
        check8("frame_done", {7'b0, frame_done}, {7'b0, exp_fd});
    endtask

    task automatic reset_mid_slot();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check8("rst_an", an, 8'hFF);
        check8("rst_seg", seg, 8'hFF);
        check8("rst_fd", {7'b0, frame_done}, 8'h00);
        @(negedge clk);
        load = 1'b0;
        rst_n = 1'b1;
        model_reset();
        step();
        check8("restart_an0", an, 8'hFF);
        step();
        check8("restart_an1", an, 8'hFE);
    endtask

    initial begin
        tbl[0]  = '{0,   8'hFF, 8'hC0, 1'b0};
`ifdef SEG_LEADING_ZERO_BLANK_EN
        tbl[1]  = '{31,  8'h7F, 8'hFF, 1'b1};
`else
        tbl[1]  = '{31,  8'h7F, 8'hC0, 1'b1};
`endif
        tbl[2]  = '{32,  8'hFF, 8'h80, 1'b0};
        tbl[3]  = '{33,  8'hFE, 8'h80, 1'b0};
        tbl[4]  = '{37,  8'hFD, 8'hF8, 1'b0};
        tbl[5]  = '{61,  8'h7F, 8'hF9, 1'b0};
        tbl[6]  = '{63,  8'h7F, 8'hF9, 1'b1};
        tbl[7]  = '{73,  8'hFB, 8'h82, 1'b0};
        tbl[8]  = '{97,  8'hFE, 8'h92, 1'b0};
        tbl[9]  = '{101, 8'hFD, 8'h88, 1'b0};
        tbl[10] = '{129, 8'hFE, 8'h8E, 1'b0};
        tbl[11] = '{157, 8'h7F, 8'h8E, 1'b0};

        model_reset();
        cur_e = 0;
        repeat (2) @(negedge clk);
        check8("reset_an", an, 8'hFF);
        check8("reset_seg", seg, 8'hFF);
        check8("reset_fd", {7'b0, frame_done}, 8'h00);
        rst_n = 1'b1;

        // Directed: initial load, mid-frame load, load on the boundary cycle
        for (int e = 0; e < 160; e++) begin
            load = (e == 0) || (e == 70) || (e == 127);
            hexs = (e == 0) ? 32'h12345678 : (e == 70) ? 32'hA5A5A5A5 : 32'hFFFFFFFF;
            step();
            for (int t = 0; t < 12; t++) begin
                if (tbl[t].edge_n == cur_e) begin
                    check8("tbl_an", an, tbl[t].an);
                    check8("tbl_seg", seg, tbl[t].seg);
                    check8("tbl_fd", {7'b0, frame_done}, {7'b0, tbl[t].fd});
                end
            end
        end

        // Blink on digit 0 with a decimal point on digit 7, then blinking disabled
        hexs = 32'h12345678; points = 8'h80; les = 8'h01; flash_en = 1'b1; load = 1'b1;
        step();
        load = 1'b0;
        repeat (8 * S * D) step();
        flash_en = 1'b0;
        repeat (4 * S * D) step();

`ifdef SEG_LEADING_ZERO_BLANK_EN
        hexs = 32'h00000120; points = 8'h00; les = 8'h00; load = 1'b1;
        step();
        load = 1'b0;
        repeat (2 * S * D) step();
        hexs = 32'h0; load = 1'b1;
        step();
        load = 1'b0;
        repeat (2 * S * D) step();
`endif

        // Randomized traffic with one asynchronous reset in the middle
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) reset_mid_slot();
            load = ($urandom_range(0, 19) == 0);
            hexs = $urandom() >> (4 * $urandom_range(0, 8));
            points = 8'($urandom());
            les = 8'($urandom());
            if ($urandom_range(0, 199) == 0) flash_en = ~flash_en;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
